// File: rtl/mem_stage_ls_if.sv
// Bundle of the MEM-stage pipeline signals between EX/MEM (master side) and
// the memory-access stage (slave side), plus FSM visibility for checkers.
//
// Handshake: the stage accepts the instruction presented on the inputs on
// every rising edge where stall_out = 0. While stall_out = 1 the master must
// hold every input (including valid_in) stable, and nothing is accepted.
interface mem_stage_ls_if #(
  parameter int XLEN = 32
);
  logic            valid_in;
  logic            mem_we;
  logic            mem_re;
  logic [2:0]      mem_size;
  logic [4:0]      addr_rd_in;
  logic            reg_file_write_in;
  logic            branch_instruction;
  logic            branch_in;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] reg_out_b;
  logic [1:0]      select_mux_2_in;

  logic            stall_out;
  logic            select_mux_3_out;
  logic            valid_out;
  logic            reg_file_write_out;
  logic [4:0]      addr_rd_out;
  logic [XLEN-1:0] mem_out;
  logic [XLEN-1:0] alu_result_out;
  logic [1:0]      select_mux_2_out;
  logic            select_mux_3_out_wb;
  logic            misaligned_out;

  // FSM visibility: 1 while in the wait state, and the remaining wait count
  logic            dbg_wait;
  logic [31:0]     dbg_cnt;

  modport master (
    output valid_in, mem_we, mem_re, mem_size, addr_rd_in, reg_file_write_in,
           branch_instruction, branch_in, alu_out, reg_out_b, select_mux_2_in,
    input  stall_out, select_mux_3_out, valid_out, reg_file_write_out,
           addr_rd_out, mem_out, alu_result_out, select_mux_2_out,
           select_mux_3_out_wb, misaligned_out, dbg_wait, dbg_cnt
  );

  modport slave (
    input  valid_in, mem_we, mem_re, mem_size, addr_rd_in, reg_file_write_in,
           branch_instruction, branch_in, alu_out, reg_out_b, select_mux_2_in,
    output stall_out, select_mux_3_out, valid_out, reg_file_write_out,
           addr_rd_out, mem_out, alu_result_out, select_mux_2_out,
           select_mux_3_out_wb, misaligned_out, dbg_wait, dbg_cnt
  );
endinterface

// File: rtl/mem_stage_ls.sv
// RISC-V MEM stage: byte/half/word loads and stores with sign/zero extension,
// misalignment detection, a LATENCY-cycle wait-state FSM that stalls
// upstream, and the MEM/WB pipeline register.
module mem_stage_ls #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input logic          clk,
  input logic          reset,
  mem_stage_ls_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            req, aligned, acc, misal, is_load;
  logic            complete, stall, mem_wr;
  logic [AW-1:0]   word_idx;
  logic [3:0]      be;
  logic [31:0]     wdata, rdata, ext_data, load_data;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic            mux3;

  logic [XLEN-1:0] mem_q [DEPTH];

  logic            valid_q, valid_d;
  logic            rfw_q, rfw_d;
  logic            br_wb_q, br_wb_d;
  logic [4:0]      rd_q;
  logic [31:0]     mem_out_q, alu_q;
  logic [1:0]      sel2_q;
  logic            misal_q;

  // Request decode and natural-alignment check by access size
  always_comb begin
    req      = bus.valid_in & (bus.mem_re | bus.mem_we);
    is_load  = bus.mem_re & ~bus.mem_we;
    word_idx = bus.alu_out[AW+1:2];
    case (bus.mem_size)
      3'b000, 3'b100: aligned = 1'b1;
      3'b001, 3'b101: aligned = ~bus.alu_out[0];
      default:        aligned = (bus.alu_out[1:0] == 2'b00);
    endcase
    acc   = req & aligned;
    misal = req & ~aligned;
    mux3  = bus.branch_instruction & bus.branch_in & bus.valid_in;
  end

  // Wait-state FSM: next state, wait counter, completion and stall
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (LATENCY == 1) begin
            complete = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = S_WAIT;
            cnt_d   = CW'(LATENCY - 2);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          complete = acc;
          state_d  = S_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Store lane enables with the store data replicated across lanes
  always_comb begin
    case (bus.mem_size)
      3'b000, 3'b100: begin
        be    = 4'b0001 << bus.alu_out[1:0];
        wdata = {4{bus.reg_out_b[7:0]}};
      end
      3'b001, 3'b101: begin
        be    = bus.alu_out[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.reg_out_b[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = bus.reg_out_b;
      end
    endcase
  end

  // A store commits only on its completion edge; reset aborts it
  assign mem_wr = complete & bus.mem_we & ~reset;

  // Data array with per-byte write enables (contents are not reset)
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[word_idx];

  // Lane select and sign/zero extension of load data
  always_comb begin
    case (bus.alu_out[1:0])
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
    rhalf = bus.alu_out[1] ? rdata[31:16] : rdata[15:0];
    case (bus.mem_size)
      3'b000:  ext_data = {{24{rbyte[7]}}, rbyte};
      3'b100:  ext_data = {24'd0, rbyte};
      3'b001:  ext_data = {{16{rhalf[15]}}, rhalf};
      3'b101:  ext_data = {16'd0, rhalf};
      default: ext_data = rdata;
    endcase
    load_data = (acc & is_load) ? ext_data : 32'd0;
  end

  // Control fields of the MEM/WB entry; a stall inserts a bubble
  always_comb begin
    valid_d = bus.valid_in;
    rfw_d   = bus.reg_file_write_in & ~misal;
    br_wb_d = mux3;
    if (stall) begin
      valid_d = 1'b0;
      rfw_d   = 1'b0;
      br_wb_d = 1'b0;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      rfw_q     <= 1'b0;
      br_wb_q   <= 1'b0;
      rd_q      <= '0;
      mem_out_q <= '0;
      alu_q     <= '0;
      sel2_q    <= '0;
      misal_q   <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      rfw_q     <= rfw_d;
      br_wb_q   <= br_wb_d;
      rd_q      <= bus.addr_rd_in;
      mem_out_q <= load_data;
      alu_q     <= bus.alu_out;
      sel2_q    <= bus.select_mux_2_in;
      misal_q   <= misal;
    end
  end

  assign bus.stall_out           = stall;
  assign bus.select_mux_3_out    = mux3;
  assign bus.valid_out           = valid_q;
  assign bus.reg_file_write_out  = rfw_q;
  assign bus.addr_rd_out         = rd_q;
  assign bus.mem_out             = mem_out_q;
  assign bus.alu_result_out      = alu_q;
  assign bus.select_mux_2_out    = sel2_q;
  assign bus.select_mux_3_out_wb = br_wb_q;
  assign bus.misaligned_out      = misal_q;
  assign bus.dbg_wait            = (state_q == S_WAIT);
  assign bus.dbg_cnt             = 32'(cnt_q);
endmodule

// File: tb/tb_mem_stage_ls.sv
// Bench for mem_stage_ls: three instances (LATENCY 1, 3, 4) share one set of
// stimulus signals; only the selected instance sees valid_in. A byte-level
// memory model predicts each cycle's stall/branch outputs and MEM/WB entry.
module tb_mem_stage_ls;
  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010,
                         SZ_BU = 3'b100, SZ_HU = 3'b101;

  typedef struct {
    int          sel;
    logic        chk_comb;
    logic        stall;
    logic        mux3;
    logic        chk_data;
    logic        chk_idle;
    logic        valid;
    logic        rfw;
    logic [4:0]  rd;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [1:0]  s2;
    logic        mux3wb;
    logic        misal;
    logic        bubble;
  } rec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        t_reset = 1'b1;
  int          t_sel = 0;
  logic        t_valid = 1'b0, t_we = 1'b0, t_re = 1'b0;
  logic [2:0]  t_sz = 3'b0;
  logic [4:0]  t_rd = 5'd0;
  logic        t_rfw = 1'b0, t_bi = 1'b0, t_br = 1'b0;
  logic [31:0] t_addr = 32'd0, t_data = 32'd0;
  logic [1:0]  t_s2 = 2'd0;

  logic [2:0]        stall_v, mux3_v, valid_v, rfw_v, mux3wb_v, misal_v, wait_v;
  logic [2:0][4:0]   rd_v;
  logic [2:0][1:0]   s2_v;
  logic [2:0][31:0]  mem_v, alu_v, cnt_v;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    mem_stage_ls_if #(.XLEN(32)) u_if ();
    assign u_if.valid_in           = t_valid & (t_sel == g);
    assign u_if.mem_we             = t_we;
    assign u_if.mem_re             = t_re;
    assign u_if.mem_size           = t_sz;
    assign u_if.addr_rd_in         = t_rd;
    assign u_if.reg_file_write_in  = t_rfw;
    assign u_if.branch_instruction = t_bi;
    assign u_if.branch_in          = t_br;
    assign u_if.alu_out            = t_addr;
    assign u_if.reg_out_b          = t_data;
    assign u_if.select_mux_2_in    = t_s2;
    assign stall_v[g]  = u_if.stall_out;
    assign mux3_v[g]   = u_if.select_mux_3_out;
    assign valid_v[g]  = u_if.valid_out;
    assign rfw_v[g]    = u_if.reg_file_write_out;
    assign rd_v[g]     = u_if.addr_rd_out;
    assign mem_v[g]    = u_if.mem_out;
    assign alu_v[g]    = u_if.alu_result_out;
    assign s2_v[g]     = u_if.select_mux_2_out;
    assign mux3wb_v[g] = u_if.select_mux_3_out_wb;
    assign misal_v[g]  = u_if.misaligned_out;
    assign wait_v[g]   = u_if.dbg_wait;
    assign cnt_v[g]    = u_if.dbg_cnt;
    mem_stage_ls #(.XLEN(32), .DEPTH(1024), .LATENCY(LAT)) u_dut (
      .clk   (clk),
      .reset (t_reset),
      .bus   (u_if.slave)
    );
  end

  // ---------------- scoreboard state ----------------
  rec_t        exp_q[$];
  logic [31:0] mmem [3][1024];
  bit          wr   [3][1024];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 3 : 4);
  endfunction

  function automatic int size_bytes(input logic [2:0] sz);
    case (sz)
      SZ_B, SZ_BU: return 1;
      SZ_H, SZ_HU: return 2;
      default:     return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] addr,
                                             input logic [2:0] sz);
    logic [31:0] v;
    v = w >> (8 * (addr % 4));
    case (sz)
      SZ_B:  begin v = v & 32'hFF;   if (v >= 32'd128)   v = v | 32'hFFFFFF00; end
      SZ_BU: v = v & 32'hFF;
      SZ_H:  begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v | 32'hFFFF0000; end
      SZ_HU: v = v & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic model_store(input int s, input int widx, input logic [31:0] addr,
                             input logic [31:0] data, input logic [2:0] sz);
    logic [31:0] w;
    int lane;
    w = mmem[s][widx];
    for (int k = 0; k < size_bytes(sz); k++) begin
      lane = int'(addr % 4) + k;
      w = (w & ~(32'hFF << (8 * lane))) | (((data >> (8 * k)) & 32'hFF) << (8 * lane));
    end
    mmem[s][widx] = w;
    wr[s][widx]   = 1'b1;
  endtask

  function automatic rec_t blank(input int s);
    rec_t r;
    r.sel = s; r.chk_comb = 1'b0; r.stall = 1'b0; r.mux3 = 1'b0; r.chk_data = 1'b1;
    r.chk_idle = 1'b0; r.valid = 1'b0; r.rfw = 1'b0; r.rd = '0; r.mem = '0; r.alu = '0;
    r.s2 = '0; r.mux3wb = 1'b0; r.misal = 1'b0; r.bubble = 1'b0;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rec_t r;
    cycle();
    t_reset = 1'b1; t_valid = 1'b0; t_we = 1'b0; t_re = 1'b0; t_bi = 1'b0; t_br = 1'b0;
    r = blank(t_sel);
    r.chk_idle = 1'b1;
    exp_q.push_back(r);
  endtask

  task automatic drive_op(input int s, input logic v, input logic we, input logic re,
                          input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, input logic rfw, input logic bi, input logic br,
                          input logic [1:0] s2, output logic [31:0] exp_mem);
    rec_t r;
    int   n, widx;
    logic req, al, ld;
    cycle();
    t_reset = 1'b0; t_sel = s; t_valid = v; t_we = we; t_re = re; t_sz = sz;
    t_addr = addr; t_data = data; t_rd = rd; t_rfw = rfw; t_bi = bi; t_br = br; t_s2 = s2;
    req  = v & (we | re);
    al   = ((addr % size_bytes(sz)) == 0);
    ld   = req & al & re & ~we;
    widx = int'((addr / 4) % 1024);
    exp_mem = ld ? model_load(mmem[s][widx], addr, sz) : 32'd0;
    n = (req && al) ? lat_of(s) - 1 : 0;
    for (int i = 0; i < n; i++) begin
      r = blank(s);
      r.chk_comb = 1'b1; r.stall = 1'b1; r.mux3 = bi & br & v; r.bubble = 1'b1;
      exp_q.push_back(r);
      cycle();
    end
    r = blank(s);
    r.chk_comb = 1'b1; r.stall = 1'b0; r.mux3 = bi & br & v;
    r.valid = v; r.rfw = rfw & ~(req & ~al); r.rd = rd; r.mem = exp_mem;
    r.chk_data = !ld || wr[s][widx]; r.alu = addr; r.s2 = s2;
    r.mux3wb = bi & br & v; r.misal = req & ~al;
    exp_q.push_back(r);
    if (req && al && we) model_store(s, widx, addr, data, sz);
  endtask

  task automatic st(input int s, input logic [2:0] sz, input logic [31:0] addr,
                    input logic [31:0] data);
    logic [31:0] e;
    drive_op(s, 1'b1, 1'b1, 1'b0, sz, addr, data, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, e);
  endtask

  task automatic ld(input int s, input logic [2:0] sz, input logic [31:0] addr,
                    output logic [31:0] e);
    drive_op(s, 1'b1, 1'b0, 1'b1, sz, addr, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 2'd1, e);
  endtask

  task automatic nop(input int s);
    logic [31:0] e;
    drive_op(s, 1'b0, 1'b0, 1'b0, SZ_W, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, e);
  endtask

  // Store on the LATENCY=4 instance, reset raised in its second wait cycle
  task automatic abort_store_l4(input logic [31:0] addr, input logic [31:0] data);
    rec_t r;
    cycle();
    t_reset = 1'b0; t_sel = 2; t_valid = 1'b1; t_we = 1'b1; t_re = 1'b0; t_sz = SZ_W;
    t_addr = addr; t_data = data; t_rd = 5'd0; t_rfw = 1'b0; t_bi = 1'b0; t_br = 1'b0;
    t_s2 = 2'd0;
    for (int i = 0; i < 2; i++) begin
      r = blank(2);
      r.chk_comb = 1'b1; r.stall = 1'b1; r.bubble = 1'b1;
      exp_q.push_back(r);
      cycle();
    end
    t_reset = 1'b1;
    r = blank(2);
    r.chk_idle = 1'b1;
    exp_q.push_back(r);
  endtask

  // ---------------- compare process ----------------
  rec_t cur, prev;
  bit   have_prev = 1'b0;

  task automatic check_wb(input rec_t r);
    int s;
    s = r.sel;
    chk("valid_out", 32'(valid_v[s]), 32'(r.valid));
    chk("reg_file_write_out", 32'(rfw_v[s]), 32'(r.rfw));
    chk("select_mux_3_out_wb", 32'(mux3wb_v[s]), 32'(r.mux3wb));
    if (!r.bubble) begin
      chk("addr_rd_out", 32'(rd_v[s]), 32'(r.rd));
      chk("alu_result_out", alu_v[s], r.alu);
      chk("select_mux_2_out", 32'(s2_v[s]), 32'(r.s2));
      chk("misaligned_out", 32'(misal_v[s]), 32'(r.misal));
      if (r.chk_data) chk("mem_out", mem_v[s], r.mem);
    end
    if (r.chk_idle) begin
      chk("fsm_idle", 32'(wait_v[s]), 32'd0);
      chk("fsm_cnt", cnt_v[s], 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (have_prev) begin
      check_wb(prev);
      have_prev = 1'b0;
    end
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      if (cur.chk_comb) begin
        chk("stall_out", 32'(stall_v[cur.sel]), 32'(cur.stall));
        chk("select_mux_3_out", 32'(mux3_v[cur.sel]), 32'(cur.mux3));
      end
      prev = cur;
      have_prev = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] e;
    logic [2:0]  sztab [8];
    int          kind;
    logic        v, we, re;
    sztab = '{SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU, 3'b011, 3'b110, 3'b111};
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 1024; w++) begin mmem[s][w] = 32'd0; wr[s][w] = 1'b0; end

    do_reset();
    do_reset();

    // LATENCY = 1: sub-word loads from a stored word
    st(0, SZ_W, 32'h10, 32'hDEADBEEF);
    ld(0, SZ_B, 32'h13, e);   chk("lit_lb", e, 32'hFFFFFFDE);
    ld(0, SZ_BU, 32'h13, e);  chk("lit_lbu", e, 32'h000000DE);
    ld(0, SZ_H, 32'h12, e);   chk("lit_lh", e, 32'hFFFFDEAD);
    // Misaligned store and load leave memory untouched
    st(0, SZ_W, 32'h12, 32'h12345678);
    ld(0, SZ_H, 32'h11, e);
    ld(0, SZ_W, 32'h10, e);   chk("lit_lw_after_misal", e, 32'hDEADBEEF);
    // Address wrap modulo DEPTH words
    st(0, SZ_W, 32'h0, 32'h0);
    st(0, SZ_B, 32'h1003, 32'h000000AA);
    ld(0, SZ_W, 32'h0, e);    chk("lit_wrap", e, 32'hAA000000);
    // Branch path through a non-memory instruction
    drive_op(0, 1'b1, 1'b0, 1'b0, SZ_W, 32'h40, 32'd0, 5'd3, 1'b1, 1'b1, 1'b1, 2'd0, e);
    nop(0);

    // LATENCY = 3: load with branch bits set, two stall cycles
    st(1, SZ_W, 32'h10, 32'hDEADBEEF);
    nop(1);
    drive_op(1, 1'b1, 1'b0, 1'b1, SZ_W, 32'h10, 32'd0, 5'd9, 1'b1, 1'b1, 1'b1, 2'd1, e);
    chk("lit_lw_lat3", e, 32'hDEADBEEF);
    nop(1);

    // LATENCY = 4: reset aborts a pending store
    st(2, SZ_W, 32'h20, 32'h11223344);
    abort_store_l4(32'h20, 32'hFFFFFFFF);
    nop(2);
    ld(2, SZ_W, 32'h20, e);   chk("lit_abort", e, 32'h11223344);

    // Randomized traffic on each instance over a small initialized window
    for (int s = 0; s < 3; s++) begin
      for (int w = 0; w < 16; w++)
        st(s, SZ_W, ($urandom & 32'hFFFFF000) | 32'(w * 4), $urandom);
      for (int i = 0; i < 60; i++) begin
        kind = $urandom_range(0, 9);
        v  = (kind != 9);
        we = (kind >= 4 && kind <= 7) || (kind == 9 && $urandom_range(0, 1) == 1);
        re = (kind <= 3) || (kind == 7) || (kind == 9 && $urandom_range(0, 1) == 1);
        drive_op(s, v, we, re, sztab[$urandom_range(0, 7)],
                 ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63)), $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), e);
      end
      nop(s);
    end

    nop(0);
    nop(0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/mem_stage_ls.md
# mem_stage_ls

Parametrised memory-access stage of the 5-stage RISC-V pipeline, sitting between the EX/MEM register and the WB stage. It extends the word-only MEM stage with byte, halfword and word loads and stores, sign or zero extension, misalignment detection and a configurable multi-cycle memory latency. Latency is handled by a wait-state FSM that stalls upstream stages. The integrated MEM/WB register carries the result to write-back.

## Interface

Parameters:
- XLEN, 32, data path width; fixed to 32 for byte-lane logic.
- DEPTH, 1024, memory size in XLEN words; must be a power of two.
- LATENCY, 1, cycles per memory access; must be ≥ 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- valid_in  in  1  instruction in MEM is valid.
- mem_we  in  1  store request.
- mem_re  in  1  load request.
- mem_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_rd_in  in  5  destination register.
- reg_file_write_in  in  1  register write enable.
- branch_instruction  in  1  branch opcode flag.
- branch_in  in  1  ALU branch condition.
- alu_out  in  XLEN  byte address / ALU result.
- reg_out_b  in  XLEN  store data.
- select_mux_2_in  in  2  WB source select.
- stall_out  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- select_mux_3_out  out  1  combinational branch taken.
- valid_out  out  1  MEM/WB entry valid.
- reg_file_write_out  out  1  registered write enable.
- addr_rd_out  out  5  registered destination register.
- mem_out  out  XLEN  registered extended load data.
- alu_result_out  out  XLEN  registered alu_out.
- select_mux_2_out  out  2  registered WB select.
- select_mux_3_out_wb  out  1  registered branch taken.
- misaligned_out  out  1  registered misaligned-access flag.

## Operation

- Access condition: acc = valid_in & (mem_re | mem_we) & aligned.
- Alignment rules:
  - H/HU requires alu_out[0] = 0.
  - W requires alu_out[1:0] = 0.
  - B/BU is always aligned.
  - Misaligned access (valid_in & (mem_re | mem_we) & !aligned): no memory write, no stall. WB receives misaligned_out = 1 and reg_file_write_out = 0.
- Word index: alu_out[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH words.
- Store byte enables:
  - B: the single lane selected by addr[1:0].
  - H: lanes {addr[1],0} and {addr[1],1}.
  - W: all four lanes.
  - Data is lane-replicated from reg_out_b[7:0] or reg_out_b[15:0].
- Load data: the byte or halfword at the addressed lane, sign-extended for B/H and zero-extended for BU/HU. mem_size 011, 110 or 111 is treated as W.
- mem_re & mem_we together: treated as a store; mem_out = 0.
- FSM states:
  - IDLE: on acc with LATENCY = 1, the access completes this cycle. On acc with LATENCY > 1, go to WAIT with cnt = LATENCY-2.
  - WAIT: cnt decrements each cycle. When cnt = 0 the current cycle is the completion cycle; next state is IDLE.
- stall_out = (IDLE & acc & LATENCY > 1) | (WAIT & cnt ≠ 0).
- Upstream must hold all inputs stable while stall_out = 1.
- Non-memory valid instructions pass through in one cycle regardless of LATENCY.
- select_mux_3_out = branch_instruction & branch_in & valid_in.
- MEM/WB register:
  - Loads all fields on every edge where stall_out = 0.
  - While stall_out = 1, it loads a bubble: valid_out = 0, reg_file_write_out = 0, select_mux_3_out_wb = 0. The data fields are don't-care.
- Memory contents are not reset.

## Timing

- Reset: all outputs 0, FSM IDLE, cnt 0, stall_out 0.
- Reset has priority over everything. Reset during WAIT aborts the access and the pending store is not committed.
- Store commit: on the rising edge ending the completion cycle, so cycle T for LATENCY = 1 or cycle T+LATENCY-1 otherwise, where T is the issue cycle.
- Load read: combinational from the array and sampled into mem_out on the same edge as completion. A load following a store to the same word sees the new data.
- Load-to-WB latency: LATENCY cycles from issue; stall_out is high for LATENCY-1 cycles.
- Back-to-back accesses: a new access can issue in the cycle after completion. Each access pays the full latency; there is no pipelining of accesses.
- Misaligned access: completes in one cycle even when LATENCY > 1.

## Test plan

- LATENCY = 1: SW 0xDEADBEEF to addr 0x10, then LB at 0x13 → mem_out = 0xFFFFFFDE. LBU at 0x13 → 0x000000DE. LH at 0x12 → 0xFFFFDEAD.
- LATENCY = 3: LW at 0x10 → stall_out high for exactly 2 cycles and valid_out = 0 in those cycles. Data 0xDEADBEEF appears in WB in cycle T+3 with reg_file_write_out = 1.
- Misaligned accesses: SW at 0x12 and LH at 0x11 → misaligned_out = 1, reg_file_write_out = 0, no stall. A subsequent LW at 0x10 returns the unchanged word.
- Address wrap with DEPTH = 1024: SB 0xAA to 0x1003 → LW at 0x0000 = 0xAA000000. The other bytes of that word are unchanged.
- LATENCY = 4 store with reset asserted in the 2nd WAIT cycle: the word is not modified, all outputs are 0 and the FSM is IDLE in the next cycle.
- Branch path: branch_instruction = 1, branch_in = 1, valid_in = 1 → select_mux_3_out = 1 combinationally and select_mux_3_out_wb = 1 one cycle later. During a load stall select_mux_3_out_wb = 0.
